// File: rtl/ysyx_25060170_fetch_unit_pkg.sv
// ============================================================================
// Module   : ysyx_25060170_pkg
// Brief    : Shared fetch-stage types and constants for the ysyx_25060170 core
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_25060170_pkg;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_VALID = 3'd2,
        S_EXEC  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_fetch_unit_if.sv
// ============================================================================
// Module   : ysyx_25060170_fetch_unit_if
// Brief    : Instruction-memory request/response bus between fetch and memory
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ysyx_25060170_fetch_unit_if;

    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;

    modport master (
        output imem_req_valid_o,
        output imem_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i,
        input  imem_rsp_err_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i,
        output imem_rsp_data_i,
        output imem_rsp_err_i
    );

endinterface

`default_nettype wire

// File: rtl/ysyx_25060170_fetch_unit.sv
// ============================================================================
// Module   : ysyx_25060170_fetch_unit
// Brief    : Multi-cycle instruction fetch stage with sticky error state
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_25060170_fetch_unit
    import ysyx_25060170_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    ysyx_25060170_fetch_unit_if.master imem,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    output logic                       inst_valid_o,
    input  wire logic                  idu_ready_i,
    input  wire logic                  wb_valid_i,
    input  wire logic [31:0]           wb_next_pc_i,
    output logic                       fetch_err_o,
    output logic [31:0]                inst_cnt_o
);

    localparam int unsigned     CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TIMEOUT_V = CW'(TIMEOUT);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [CW-1:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            cnt_q   <= 32'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_REQ: begin
                if (imem.imem_req_ready_i) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                // A response in the timeout cycle still wins over the timeout.
                if (imem.imem_rsp_valid_i) begin
                    if (imem.imem_rsp_err_i) begin
                        state_d = S_ERR;
                    end else begin
                        inst_d  = imem.imem_rsp_data_i;
                        state_d = S_VALID;
                    end
                end else if (wait_q == TIMEOUT_V) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_VALID: begin
                if (idu_ready_i) begin
                    state_d = S_EXEC;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            S_EXEC: begin
                if (wb_valid_i) begin
                    if (wb_next_pc_i[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d    = wb_next_pc_i;
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    assign imem.imem_req_valid_o = (state_q == S_REQ);
    assign imem.imem_addr_o      = pc_q;
    assign inst_o                = inst_q;
    assign pc_o                  = pc_q;
    assign inst_valid_o          = (state_q == S_VALID);
    assign fetch_err_o           = (state_q == S_ERR);
    assign inst_cnt_o            = cnt_q;

endmodule

`default_nettype wire

// File: doc/ysyx_25060170_fetch_unit.md
# ysyx_25060170_fetch_unit

Instruction fetch stage of the ysyx_25060170 multi-cycle core, sitting directly upstream of the decode stage. It owns the architectural PC and issues one instruction-memory read per instruction over a valid/ready request channel. It presents the fetched word and its PC to decode, then waits for write-back to commit the next PC before fetching again. Memory errors, misaligned next-PCs and response timeouts park it in a sticky error state.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.
- TIMEOUT, 255, maximum cycles in WAIT before a timeout error; width of the wait counter is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_addr_o  out  32  fetch address; always equals pc_o.
- imem_rsp_valid_i  in  1  read data valid, one-cycle pulse.
- imem_rsp_data_i  in  32  instruction word.
- imem_rsp_err_i  in  1  access fault; qualified by imem_rsp_valid_i.
- inst_o  out  32  registered instruction to decode.
- pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/pc_o valid for decode.
- idu_ready_i  in  1  decode accepts instruction (decode's ready output).
- wb_valid_i  in  1  write-back commit pulse.
- wb_next_pc_i  in  32  next PC from write-back; qualified by wb_valid_i.
- fetch_err_o  out  1  sticky error flag.
- inst_cnt_o  out  32  count of instructions handed to decode.

## Operation
- States: REQ, WAIT, VALID, EXEC, ERR.
- Reset values: state REQ, pc_o = RESET_PC, inst_o = 32'h0000_0013, inst_valid_o 0, fetch_err_o 0, inst_cnt_o 0, wait counter 0.
- REQ: imem_req_valid_o = 1, imem_addr_o = pc_o. On imem_req_ready_i, go to WAIT and clear the wait counter.
- WAIT: imem_req_valid_o = 0.
  - On imem_rsp_valid_i with err = 0: latch inst_o and go to VALID.
  - On imem_rsp_valid_i with err = 1: go to ERR; inst_o is unchanged.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT with no response, go to ERR.
- VALID: inst_valid_o = 1, with inst_o and pc_o held stable. On idu_ready_i, go to EXEC and increment inst_cnt_o (wraps modulo 2^32).
- EXEC: inst_valid_o = 0; inst_o and pc_o are held for downstream use. On wb_valid_i:
  - If wb_next_pc_i[1:0] != 0: go to ERR; pc_o is unchanged.
  - Otherwise load pc_o from wb_next_pc_i and go to REQ.
- ERR: terminal until reset. fetch_err_o = 1; no requests issued; inst_valid_o = 0.
- Ignored inputs (no effect in these states):
  - imem_rsp_valid_i outside WAIT.
  - wb_valid_i outside EXEC.
  - idu_ready_i outside VALID.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Fetch latency: request accepted in cycle N, response no earlier than N+1, inst_valid_o asserted in the cycle after the response edge.
- Minimum loop with zero-wait memory and immediate ready/commit: REQ → WAIT → VALID → EXEC → REQ, i.e. 4 cycles per instruction.
- imem_addr_o is stable while imem_req_valid_o is high; the request is never withdrawn before ready.
- Timeout boundary: a response arriving in the same cycle the counter equals TIMEOUT is accepted; the response has priority over the timeout.
- Reset mid-operation (any state, including WAIT with a response outstanding): all registers take reset values immediately. The first request after rst_n rises issues in the first clock edge's cycle. A stale response arriving afterwards in REQ is ignored.

## Structure
- Shared package ysyx_25060170_pkg holds:
  - the fetch state enum;
  - the NOP constant 32'h0000_0013;
  - the default RESET_PC.
- Single module; the wait-timeout counter is inline, and no sub-module is required.

## Test plan
- Reset release with zero-wait memory: first request has addr 0x8000_0000. inst_valid_o rises 2 cycles after request acceptance. inst_o equals the returned word.
- Loop with commit of next PC 0x8000_0004 and then 0x8000_0100: the next two imem_addr_o values are 0x8000_0004 and 0x8000_0100; inst_cnt_o = 2 after two handshakes.
- Decode backpressure: idu_ready_i low for 5 cycles → inst_valid_o, inst_o and pc_o stay stable; inst_cnt_o increments exactly once on acceptance.
- Error paths, each leading to ERR with fetch_err_o high and no further requests:
  - imem_rsp_err_i asserted with the response;
  - wb_next_pc_i = 0x8000_0002 committed;
  - response withheld for TIMEOUT+1 cycles.
- Response exactly at cycle TIMEOUT is accepted normally; wb_valid_i pulsed during VALID is ignored and pc_o is unchanged.
- rst_n asserted in WAIT: outputs take reset values asynchronously. After release, a stale rsp_valid in REQ is ignored and the fetch restarts at RESET_PC.
